// File: rtl/seg7_pkg.sv
// Shared constants, display-image type and blanking helper for the
// 4-digit multiplexed 7-segment scan controller.
package seg7_pkg;

    localparam int unsigned N_DIGITS = 4;
    localparam logic [6:0]  SEG_OFF  = 7'b1111111;
    localparam logic [3:0]  AN_OFF   = 4'b1111;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic        blank_lz;
        logic [3:0]  mask;
    } disp_img_t;

    // Digit i (3..1) is a leading zero when it and every higher nibble are zero.
    function automatic logic [3:0] lz_blank(input logic [15:0] v);
        logic [3:0] b;
        b[3] = (v[15:12] == 4'h0);
        b[2] = b[3] && (v[11:8] == 4'h0);
        b[1] = b[2] && (v[7:4] == 4'h0);
        b[0] = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low 7-segment pattern, segment a in bit 6, g in bit 0.
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        unique case (hex)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'ha: seg = 7'b0001000;
            4'hb: seg = 7'b1100000;
            4'hc: seg = 7'b0110001;
            4'hd: seg = 7'b1000010;
            4'he: seg = 7'b0110000;
            4'hf: seg = 7'b0111000;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit common-anode scan controller with a double-buffered
// display image, leading-zero blanking, decimal points and per-digit blink.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    input  logic [3:0]  blink_mask,
    input  logic        load,
    output logic        load_ack,
    output logic [3:0]  an,
    output logic [6:0]  a_to_g,
    output logic        dp,
    output logic        frame_tick
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned DW = $clog2(N_DIGITS);

    localparam logic [PW-1:0] PRESC_MAX  = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX  = BW'(BLINK_FRAMES - 1);
    localparam logic [DW-1:0] LAST_DIGIT = DW'(N_DIGITS - 1);

    logic [PW-1:0] presc_q;
    logic [DW-1:0] digit_sel_q;
    logic [BW-1:0] blink_cnt_q;
    logic          blink_phase_q;
    disp_img_t     pend_q;
    logic          pend_valid_q;
    disp_img_t     act_q;

    logic          presc_tc;
    logic          frame_end;
    disp_img_t     load_img;
    logic [3:0]    nibble;
    logic [6:0]    seg_dec;
    logic [3:0]    lz;
    logic          digit_blank;

    always_comb begin
        presc_tc  = (presc_q == PRESC_MAX);
        frame_end = presc_tc && (digit_sel_q == LAST_DIGIT);

        load_img          = '0;
        load_img.value    = value;
        load_img.dp       = dp_in;
        load_img.blank_lz = blank_lz;
        load_img.mask     = blink_mask;

        nibble      = act_q.value[{digit_sel_q, 2'b00} +: 4];
        lz          = lz_blank(act_q.value);
        digit_blank = (act_q.blank_lz && lz[digit_sel_q])
                   || (blink_phase_q && act_q.mask[digit_sel_q]);
    end

    hex7seg u_hex7seg (
        .hex (nibble),
        .seg (seg_dec)
    );

    // Scan timing, blink timing and the pending/active double buffer.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            presc_q       <= '0;
            digit_sel_q   <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pend_q        <= '0;
            pend_valid_q  <= 1'b0;
            act_q         <= '0;
            load_ack      <= 1'b0;
            frame_tick    <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            load_ack   <= 1'b0;

            if (presc_tc) begin
                presc_q     <= '0;
                digit_sel_q <= digit_sel_q + DW'(1);
            end else begin
                presc_q <= presc_q + PW'(1);
            end

            if (frame_end) begin
                if (blink_cnt_q == BLINK_MAX) begin
                    blink_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BW'(1);
                end
            end

            // A load on the boundary cycle defers the transfer a whole frame.
            if (load) begin
                pend_q       <= load_img;
                pend_valid_q <= 1'b1;
            end else if (frame_end && pend_valid_q) begin
                act_q        <= pend_q;
                pend_valid_q <= 1'b0;
                load_ack     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            an     <= AN_OFF;
            a_to_g <= SEG_OFF;
            dp     <= 1'b1;
        end else if (digit_blank) begin
            an     <= AN_OFF;
            a_to_g <= SEG_OFF;
            dp     <= 1'b1;
        end else begin
            an     <= ~(4'b0001 << digit_sel_q);
            a_to_g <= seg_dec;
            dp     <= ~act_q.dp[digit_sel_q];
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with REFRESH_DIV = 4 and BLINK_FRAMES = 2.
module tb_seg7_scan_ctrl;

    localparam logic [6:0] S_0 = 7'b0000001;
    localparam logic [6:0] S_1 = 7'b1001111;
    localparam logic [6:0] S_2 = 7'b0010010;
    localparam logic [6:0] S_3 = 7'b0000110;
    localparam logic [6:0] S_4 = 7'b1001100;
    localparam logic [6:0] S_5 = 7'b0100100;
    localparam logic [6:0] S_7 = 7'b0001111;
    localparam logic [6:0] S_A = 7'b0001000;
    localparam logic [6:0] S_B = 7'b1100000;
    localparam logic [6:0] S_C = 7'b0110001;
    localparam logic [6:0] S_D = 7'b1000010;
    localparam logic [6:0] S_F = 7'b0111000;
    localparam logic [6:0] S_X = 7'b1111111;

    logic        clk = 1'b0;
    logic        clr_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [3:0]  blink_mask;
    logic        load;
    logic        load_ack;
    logic [3:0]  an;
    logic [6:0]  a_to_g;
    logic        dp;
    logic        frame_tick;

    int checks   = 0;
    int failures = 0;

    // {value, dp_in, blank_lz, blink_mask} for the two loads a frame may carry.
    logic [24:0] img_a;
    logic [24:0] img_b;
    logic [15:0] an_tab = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

    seg7_scan_ctrl #(
        .REFRESH_DIV  (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .value      (value),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .load       (load),
        .load_ack   (load_ack),
        .an         (an),
        .a_to_g     (a_to_g),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_off(input string tag);
        chk({tag, ".an"}, {3'b000, an}, 7'b0001111);
        chk({tag, ".seg"}, a_to_g, S_X);
        chk({tag, ".dp"}, {6'd0, dp}, 7'd1);
        chk({tag, ".ack"}, {6'd0, load_ack}, 7'd0);
        chk({tag, ".tick"}, {6'd0, frame_tick}, 7'd0);
    endtask

    // One 16-cycle frame; segs = {d3,d2,d1,d0}; la/lb = step index of a load of img_a/img_b.
    task automatic run_frame(input string tag, input logic [27:0] segs, input logic [3:0] blanked,
                             input logic [3:0] dps, input logic ack, input int la, input int lb);
        for (int i = 0; i < 16; i++) begin
            int         d;
            logic [3:0] e_an;
            logic [6:0] e_seg;
            logic       e_dp;
            string      t;
            d = i / 4;
            if (i == la) begin
                load = 1'b1;
                {value, dp_in, blank_lz, blink_mask} = img_a;
            end else if (i == lb) begin
                load = 1'b1;
                {value, dp_in, blank_lz, blink_mask} = img_b;
            end
            @(posedge clk);
            #1;
            load  = 1'b0;
            e_an  = blanked[d] ? 4'b1111 : an_tab[d*4 +: 4];
            e_seg = blanked[d] ? S_X : segs[d*7 +: 7];
            e_dp  = blanked[d] ? 1'b1 : ~dps[d];
            t = $sformatf("%s.s%0d", tag, i);
            chk({t, ".an"}, {3'b000, an}, {3'b000, e_an});
            chk({t, ".seg"}, a_to_g, e_seg);
            chk({t, ".dp"}, {6'd0, dp}, {6'd0, e_dp});
            chk({t, ".tick"}, {6'd0, frame_tick}, {6'd0, i == 15});
            chk({t, ".ack"}, {6'd0, load_ack}, {6'd0, (i == 15) && ack});
        end
    endtask

    initial begin
        clr_n      = 1'b0;
        load       = 1'b0;
        value      = '0;
        dp_in      = '0;
        blank_lz   = 1'b0;
        blink_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        check_off("reset");
        @(negedge clk);
        clr_n = 1'b1;

        // F0: reset image, all digits '0'.
        run_frame("f0", {S_0, S_0, S_0, S_0}, 4'b0000, 4'b0000, 1'b0, -1, -1);
        // F1: mid-frame load of 12AF; display unchanged until the boundary.
        img_a = {16'h12af, 4'b0100, 1'b0, 4'b0000};
        run_frame("f1", {S_0, S_0, S_0, S_0}, 4'b0000, 4'b0000, 1'b1, 6, -1);
        // F2: shows 12AF with dp on digit 2; load 0050 with leading-zero blanking.
        img_a = {16'h0050, 4'b0000, 1'b1, 4'b0000};
        run_frame("f2", {S_1, S_2, S_A, S_F}, 4'b0000, 4'b0100, 1'b1, 3, -1);
        // F3: digits 3,2 blanked; load 1234 blinking digit 0.
        img_a = {16'h1234, 4'b0000, 1'b0, 4'b0001};
        run_frame("f3", {S_0, S_0, S_5, S_0}, 4'b1100, 4'b0000, 1'b1, 10, -1);
        // F4..F8: digit 0 visible 2 frames, blanked 2 frames, visible again.
        run_frame("f4", {S_1, S_2, S_3, S_4}, 4'b0000, 4'b0000, 1'b0, -1, -1);
        run_frame("f5", {S_1, S_2, S_3, S_4}, 4'b0000, 4'b0000, 1'b0, -1, -1);
        run_frame("f6", {S_1, S_2, S_3, S_4}, 4'b0001, 4'b0000, 1'b0, -1, -1);
        run_frame("f7", {S_1, S_2, S_3, S_4}, 4'b0001, 4'b0000, 1'b0, -1, -1);
        // F8: load on the exact boundary cycle gives no ack here.
        img_a = {16'habcd, 4'b0000, 1'b0, 4'b0000};
        run_frame("f8", {S_1, S_2, S_3, S_4}, 4'b0000, 4'b0000, 1'b0, 15, -1);
        run_frame("f9", {S_1, S_2, S_3, S_4}, 4'b0000, 4'b0000, 1'b1, -1, -1);
        // F10: shows ABCD; two loads, only the second may reach the display.
        img_a = {16'h5555, 4'b0000, 1'b0, 4'b0000};
        img_b = {16'h0007, 4'b0000, 1'b0, 4'b0000};
        run_frame("f10", {S_A, S_B, S_C, S_D}, 4'b0000, 4'b0000, 1'b1, 2, 9);
        run_frame("f11", {S_0, S_0, S_0, S_7}, 4'b0000, 4'b0000, 1'b0, -1, -1);

        // Reset while a load is pending, between clock edges.
        load  = 1'b1;
        value = 16'h9999;
        @(posedge clk);
        #1;
        load = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_reset.an", {3'b000, an}, 7'b0001110);
        clr_n = 1'b0;
        #1;
        check_off("async_reset");
        repeat (3) @(posedge clk);
        #1;
        check_off("held_reset");
        @(negedge clk);
        clr_n = 1'b1;
        run_frame("r0", {S_0, S_0, S_0, S_0}, 4'b0000, 4'b0000, 1'b0, -1, -1);
        run_frame("r1", {S_0, S_0, S_0, S_0}, 4'b0000, 4'b0000, 1'b0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
